multi_lane_pipe_reg: RTL

- Parametrised inter-stage pipeline register for the multi-issue MIPS32 core. It replaces the hand-written per-stage sig/data register pairs (ID→EX, EX→MA, MA→WB).
- Carries LANES parallel instruction slots, each with a signal word, a data word and a lane-valid bit, over a ready/valid handshake with a 2-entry skid buffer.
- Adds stall back-pressure, whole-stage flush and younger-lane kill (branch in lane k squashes lanes >k).
- Generates the one-hot register-write mask from the head bundle for ID-stage hazard clearing.

---
 rtl/multi_lane_pipe_reg.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_lane_pipe_reg.sv
// ---------------------------------------------------------------------------
// multi_lane_pipe_reg
//
// Inter-stage pipeline register for the multi-issue core. It carries LANES
// instruction slots per bundle (signal word, data word, lane-valid bit)
// through a two-entry skid buffer (head + skid).
//
// Handshake: a bundle moves upstream->stage on an edge where
// in_valid && in_ready, and stage->downstream on an edge where
// out_valid && out_ready. A valid is never withdrawn by this stage while it
// waits for ready, and in_ready is registered (it equals "skid empty").
//
// Ports:
//   CLK, RST_N             clock (rising edge), async active-low reset
//   in_valid / in_ready    upstream handshake
//   in_lane_valid/sig/data incoming bundle, lane i at [i*W +: W]
//   out_valid / out_ready  downstream handshake
//   out_lane_valid/sig/data head bundle after kill masking; invalid lanes
//                          read 0 in out_sig, out_data is not lane-masked
//   flush                  clears both entries at the edge (wins over all)
//   kill_en, kill_lane     squash head lanes younger than kill_lane
//   out_wmask              one-hot OR of head destination registers ($zero
//                          excluded), used for ID-stage hazard clearing
// ---------------------------------------------------------------------------
module multi_lane_pipe_reg #(
    parameter int LANES     = 2,
    parameter int SIG_W     = 32,
    parameter int DATA_W    = 32,
    parameter int WE_BIT    = 17,
    parameter int WADDR_LSB = 12,
    parameter int WADDR_W   = 5,
    localparam int REG_N    = 2 ** WADDR_W,
    localparam int KL_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*SIG_W-1:0]  in_sig,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*SIG_W-1:0]  out_sig,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    flush,
    input  logic                    kill_en,
    input  logic [KL_W-1:0]         kill_lane,
    output logic [REG_N-1:0]        out_wmask
);

    // Entry storage
    logic                    head_occ,  skid_occ;
    logic [LANES-1:0]        head_lv,   skid_lv;
    logic [LANES*SIG_W-1:0]  head_sig,  skid_sig;
    logic [LANES*DATA_W-1:0] head_data, skid_data;
    logic                    in_ready_q;

    // Next-state values
    logic                    head_occ_n,  skid_occ_n;
    logic [LANES-1:0]        head_lv_n,   skid_lv_n;
    logic [LANES*SIG_W-1:0]  head_sig_n,  skid_sig_n;
    logic [LANES*DATA_W-1:0] head_data_n, skid_data_n;
    logic                    in_ready_n;

    logic             accept;
    logic             drain;
    logic [LANES-1:0] kill_keep;
    logic [LANES-1:0] head_lv_k;

    assign accept = in_valid && in_ready_q;
    assign drain  = head_occ && out_ready;

    // Lanes strictly younger than kill_lane are squashed; a kill_lane at or
    // beyond the last lane therefore keeps everything.
    always_comb begin
        kill_keep = '1;
        for (int i = 0; i < LANES; i++) begin
            if (kill_en && (i > int'(kill_lane))) begin
                kill_keep[i] = 1'b0;
            end
        end
    end

    assign head_lv_k = head_lv & kill_keep;

    // Next-state logic
    always_comb begin
        head_occ_n  = head_occ;
        head_lv_n   = head_lv;
        head_sig_n  = head_sig;
        head_data_n = head_data;
        skid_occ_n  = skid_occ;
        skid_lv_n   = skid_lv;
        skid_sig_n  = skid_sig;
        skid_data_n = skid_data;

        if (flush) begin
            // The bundle accepted in this cycle is dropped as well.
            head_occ_n = 1'b0;
            skid_occ_n = 1'b0;
        end else if (!head_occ) begin
            // Skid is never occupied while the head is empty.
            if (accept) begin
                head_occ_n  = 1'b1;
                head_lv_n   = in_lane_valid;
                head_sig_n  = in_sig;
                head_data_n = in_data;
            end
        end else if (drain) begin
            if (skid_occ) begin
                head_lv_n   = skid_lv;
                head_sig_n  = skid_sig;
                head_data_n = skid_data;
                if (accept) begin
                    skid_lv_n   = in_lane_valid;
                    skid_sig_n  = in_sig;
                    skid_data_n = in_data;
                end else begin
                    skid_occ_n = 1'b0;
                end
            end else if (accept) begin
                head_lv_n   = in_lane_valid;
                head_sig_n  = in_sig;
                head_data_n = in_data;
            end else begin
                head_occ_n = 1'b0;
            end
        end else begin
            // Head is stalled: make the kill stick so it survives kill_en
            // dropping before the head finally drains.
            head_lv_n = head_lv_k;
            if (accept) begin
                skid_occ_n  = 1'b1;
                skid_lv_n   = in_lane_valid;
                skid_sig_n  = in_sig;
                skid_data_n = in_data;
            end
        end

        in_ready_n = !skid_occ_n;
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_occ   <= 1'b0;
            head_lv    <= '0;
            head_sig   <= '0;
            head_data  <= '0;
            skid_occ   <= 1'b0;
            skid_lv    <= '0;
            skid_sig   <= '0;
            skid_data  <= '0;
            in_ready_q <= 1'b1;
        end else begin
            head_occ   <= head_occ_n;
            head_lv    <= head_lv_n;
            head_sig   <= head_sig_n;
            head_data  <= head_data_n;
            skid_occ   <= skid_occ_n;
            skid_lv    <= skid_lv_n;
            skid_sig   <= skid_sig_n;
            skid_data  <= skid_data_n;
            in_ready_q <= in_ready_n;
        end
    end

    // Output logic
    assign in_ready  = in_ready_q;
    assign out_valid = head_occ;

    always_comb begin
        out_lane_valid = head_occ ? head_lv_k : '0;
        out_data       = head_occ ? head_data : '0;
        out_sig        = '0;
        for (int i = 0; i < LANES; i++) begin
            if (out_lane_valid[i]) begin
                out_sig[i*SIG_W +: SIG_W] = head_sig[i*SIG_W +: SIG_W];
            end
        end
    end

    always_comb begin
        logic [SIG_W-1:0]   lane_sig;
        logic [WADDR_W-1:0] lane_waddr;
        out_wmask  = '0;
        lane_sig   = '0;
        lane_waddr = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sig   = out_sig[i*SIG_W +: SIG_W];
            lane_waddr = lane_sig[WADDR_LSB +: WADDR_W];
            if (out_lane_valid[i] && lane_sig[WE_BIT]) begin
                out_wmask[lane_waddr] = 1'b1;
            end
        end
        // Register 0 is hard-wired zero and never a hazard.
        out_wmask[0] = 1'b0;
    end

endmodule
